i2s_tx_scheduler: RTL and testbench

Sequencing controller for the `i2s_core` serializer. Runs on the system clock and generates `SCLK` and `LRCLK` by division, with SCLK = 64 × LRCLK. Accepts stereo sample pairs from the synth mixer over a valid/ready handshake, keeping one pair pending behind the pair currently playing. Presents `writedata` and `write` so the core loads the left word on the LRCLK fall and the right word on the LRCLK rise; it also detects and counts underruns.

---
 rtl/i2s_tx_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_i2s_tx_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_scheduler.sv
// rtl/i2s_tx_scheduler.sv - sequencing controller feeding an i2s_core serializer
//
// Divides Clk down to SCLK and LRCLK (SCLK = 64 x LRCLK). It accepts stereo pairs
// over a valid/ready handshake and holds one pair pending behind the pair now
// playing. It presents writedata/write so the core loads the left word on the
// LRCLK fall and the right word on the LRCLK rise. Frames that start with nothing
// pending are underruns: they play silence and are counted.
//
// Ports:
//   Clk, Reset      system clock; synchronous active-high reset
//   enable          start/stop request (level)
//   sample_l/_r     upstream stereo pair, DW bits each
//   sample_valid    upstream pair valid
//   sample_ready    pair accepted when sample_valid && sample_ready
//   SCLK, LRCLK     bit clock and word clock (LRCLK = 0 is the left slot)
//   writedata       word for the core to load
//   write           core enable
//   frame_tick      one-cycle pulse at each frame start
//   underrun_cnt    saturating underrun count

module i2s_tx_scheduler #(
  parameter int DW       = 32,
  parameter int HALF_DIV = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          enable,
  input  logic [DW-1:0] sample_l,
  input  logic [DW-1:0] sample_r,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          SCLK,
  output logic          LRCLK,
  output logic [DW-1:0] writedata,
  output logic          write,
  output logic          frame_tick,
  output logic [15:0]   underrun_cnt
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    STOP
  } state_t;

  state_t state;
  state_t state_next;

  // pending pair and the pair currently playing
  logic [DW-1:0] pend_l;
  logic [DW-1:0] pend_r;
  logic          pend_full;
  logic [DW-1:0] cur_l;
  logic [DW-1:0] cur_r;

  // clock generation
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic             sclk_q;
  logic             lrclk_q;

  logic             tick_q;
  logic [15:0]      urun_q;

  // decoded timing events
  logic div_wrap;
  logic sclk_fall;
  logic slot_end;
  logic lr_rise_ev;
  logic lr_fall_ev;
  logic accept;

  // control strobes from the FSM
  logic clocks_run;
  logic frame_begin;
  logic underrun;
  logic clear_all;

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign sclk_fall  = div_wrap && sclk_q;
  assign slot_end   = sclk_fall && (bit_cnt == 5'd31);
  assign lr_rise_ev = slot_end && !lrclk_q;
  assign lr_fall_ev = slot_end && lrclk_q;
  assign accept     = sample_valid && sample_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    sample_ready = 1'b0;
    write        = 1'b0;
    clocks_run   = 1'b0;
    frame_begin  = 1'b0;
    underrun     = 1'b0;
    clear_all    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = START;
        end
      end
      START: begin
        sample_ready = !pend_full;
        if (!enable) begin
          state_next = IDLE;
          clear_all  = 1'b1;
        end else if (pend_full) begin
          frame_begin = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        write        = 1'b1;
        clocks_run   = 1'b1;
        sample_ready = !pend_full;
        // The boundary decision uses pend_full as it stood before this
        // edge, so a pair accepted on an underrun boundary waits a frame.
        if (lr_fall_ev) begin
          if (pend_full) begin
            frame_begin = 1'b1;
          end else begin
            underrun = 1'b1;
          end
        end
        if (!enable) begin
          state_next = STOP;
        end
      end
      STOP: begin
        write      = 1'b1;
        clocks_run = 1'b1;
        // Finish the frame in flight, then drop to IDLE at the boundary
        // instead of starting the pending pair.
        if (lr_fall_ev) begin
          state_next = IDLE;
          clear_all  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        clear_all  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend_l    <= '0;
      pend_r    <= '0;
      pend_full <= 1'b0;
      cur_l     <= '0;
      cur_r     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      tick_q    <= 1'b0;
      urun_q    <= '0;
    end else begin
      tick_q <= 1'b0;

      if (accept) begin
        pend_l    <= sample_l;
        pend_r    <= sample_r;
        pend_full <= 1'b1;
      end

      if (clocks_run) begin
        div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
        if (div_wrap) begin
          sclk_q <= ~sclk_q;
        end
        if (sclk_fall) begin
          if (bit_cnt == 5'd31) begin
            bit_cnt <= '0;
            lrclk_q <= ~lrclk_q;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
      end

      // Timing is reloaded explicitly so the START -> RUN entry lines up with
      // a boundary that came from free-running counters.
      if (frame_begin) begin
        cur_l     <= pend_l;
        cur_r     <= pend_r;
        pend_full <= 1'b0;
        tick_q    <= 1'b1;
        lrclk_q   <= 1'b0;
        sclk_q    <= 1'b0;
        div_cnt   <= '0;
        bit_cnt   <= '0;
      end

      // Starved frame: play silence and leave the clocks untouched.
      if (underrun) begin
        cur_l  <= '0;
        cur_r  <= '0;
        tick_q <= 1'b1;
        if (urun_q != 16'hFFFF) begin
          urun_q <= urun_q + 16'd1;
        end
      end

      if (clear_all) begin
        pend_l    <= '0;
        pend_r    <= '0;
        pend_full <= 1'b0;
        cur_l     <= '0;
        cur_r     <= '0;
        div_cnt   <= '0;
        bit_cnt   <= '0;
        sclk_q    <= 1'b0;
        lrclk_q   <= 1'b0;
      end
    end
  end

  // cur_* change only at LRCLK falls, so this mux moves only on LRCLK edges
  // and stays stable for the whole slot.
  assign writedata    = lrclk_q ? cur_r : cur_l;
  assign SCLK         = sclk_q;
  assign LRCLK        = lrclk_q;
  assign frame_tick   = tick_q;
  assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// tb/tb_i2s_tx_scheduler.sv - self-checking bench for i2s_tx_scheduler

module tb_i2s_tx_scheduler;

  localparam int DW = 32;
  localparam int HD = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          enable;
  logic [DW-1:0] sample_l;
  logic [DW-1:0] sample_r;
  logic          sample_valid;
  logic          sample_ready;
  logic          SCLK;
  logic          LRCLK;
  logic [DW-1:0] writedata;
  logic          write;
  logic          frame_tick;
  logic [15:0]   underrun_cnt;

  i2s_tx_scheduler #(.DW(DW), .HALF_DIV(HD)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .enable       (enable),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .SCLK         (SCLK),
    .LRCLK        (LRCLK),
    .writedata    (writedata),
    .write        (write),
    .frame_tick   (frame_tick),
    .underrun_cnt (underrun_cnt)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard / monitor state
  logic [63:0] exp_q[$];
  logic [63:0] inflight;
  bit          inflight_v = 0;
  logic [15:0] m_urun = '0;
  logic [31:0] cur_exp = '0;
  logic [31:0] exp_r = '0;
  int          tick_cyc = 0;
  int          last_chg = 0;
  bit          have_tick = 0;
  logic        prev_write = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_lr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pairs accepted at an edge only join the queue after that edge's frame
  // decision, so an accept on an underrun boundary is kept for the next frame.
  task automatic monitor();
    logic [63:0] p;
    forever begin
      @(negedge Clk);
      #1;
      if (Reset) begin
        exp_q.delete();
        inflight_v = 0;
        m_urun     = '0;
        have_tick  = 0;
        cur_exp    = '0;
        exp_r      = '0;
      end else begin
        if (prev_write && !write) begin
          exp_q.delete();
          inflight_v = 0;
        end
        if (write && prev_write && (SCLK != prev_sclk)) begin
          chk("sclk_half_period", 64'(cyc - last_chg), 64'(HD));
          last_chg = cyc;
          if (SCLK) chk("writedata_stable_at_sclk_rise", 64'(writedata), 64'(cur_exp));
        end
        if (frame_tick) begin
          if (have_tick) chk("frame_period", 64'(cyc - tick_cyc), 64'(128 * HD));
          tick_cyc  = cyc;
          have_tick = 1;
          last_chg  = cyc;
          if (exp_q.size() > 0) begin
            p       = exp_q.pop_front();
            cur_exp = p[63:32];
            exp_r   = p[31:0];
          end else begin
            if (m_urun != 16'hFFFF) m_urun = m_urun + 16'd1;
            cur_exp = '0;
            exp_r   = '0;
          end
          chk("tick_writedata_left", 64'(writedata), 64'(cur_exp));
          chk("tick_underrun_cnt", 64'(underrun_cnt), 64'(m_urun));
          chk("tick_lrclk_low", 64'(LRCLK), 64'(0));
          chk("tick_sclk_low", 64'(SCLK), 64'(0));
        end
        if (write && LRCLK && !prev_lr) begin
          chk("lrclk_rise_time", 64'(cyc - tick_cyc), 64'(64 * HD));
          chk("lrclk_rise_writedata_right", 64'(writedata), 64'(exp_r));
          cur_exp = exp_r;
        end
        if (inflight_v) exp_q.push_back(inflight);
        inflight_v = 0;
        if (sample_valid && sample_ready) begin
          inflight   = {sample_l, sample_r};
          inflight_v = 1;
        end
        if (!write) have_tick = 0;
      end
      prev_write = write;
      prev_sclk  = SCLK;
      prev_lr    = LRCLK;
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic offer(input logic [31:0] l, input logic [31:0] r);
    int n = 0;
    sample_l     = l;
    sample_r     = r;
    sample_valid = 1'b1;
    while (!sample_ready && n < 600) begin
      @(negedge Clk);
      n++;
    end
    chk("offer_accepted", 64'(sample_ready), 64'(1));
    @(negedge Clk);
  endtask

  task automatic wait_tick(output int tcyc);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!frame_tick && n < 300);
    chk("frame_tick_seen", 64'(frame_tick), 64'(1));
    tcyc = cyc;
  endtask

  initial begin
    int t;
    int t0;
    int acc_prev;
    int n;
    bit saw_tick;
    logic [15:0] urun_before;

    Reset        = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge Clk);
    chk("reset_sclk", 64'(SCLK), 64'(0));
    chk("reset_lrclk", 64'(LRCLK), 64'(0));
    chk("reset_write", 64'(write), 64'(0));
    chk("reset_writedata", 64'(writedata), 64'(0));
    chk("reset_frame_tick", 64'(frame_tick), 64'(0));
    chk("reset_sample_ready", 64'(sample_ready), 64'(0));
    chk("reset_underrun_cnt", 64'(underrun_cnt), 64'(0));
    Reset  = 1'b0;
    enable = 1'b1;

    // basic frame
    offer(32'h12345678, 32'h9ABCDEF0);
    sample_valid = 1'b0;
    chk("start_latency_no_tick_yet", 64'(frame_tick), 64'(0));
    @(negedge Clk);
    chk("start_latency_tick", 64'(frame_tick), 64'(1));
    chk("basic_left_word", 64'(writedata), 64'h12345678);
    chk("basic_write_high", 64'(write), 64'(1));
    t0 = cyc;
    repeat (127) @(negedge Clk);
    chk("basic_lrclk_still_low", 64'(LRCLK), 64'(0));
    @(negedge Clk);
    chk("basic_lrclk_rise_at_128", 64'(LRCLK), 64'(1));
    chk("basic_right_word", 64'(writedata), 64'h9ABCDEF0);

    // underrun
    wait_tick(t);
    chk("basic_frame_spacing", 64'(t - t0), 64'(256));
    chk("underrun1_writedata", 64'(writedata), 64'(0));
    chk("underrun1_cnt", 64'(underrun_cnt), 64'(1));
    wait_tick(t);
    chk("underrun2_cnt", 64'(underrun_cnt), 64'(2));
    repeat (255) @(negedge Clk);
    offer(32'hB0DA0001, 32'hB0DA0002);
    sample_valid = 1'b0;
    chk("boundary_accept_tick", 64'(frame_tick), 64'(1));
    chk("boundary_accept_still_underrun", 64'(underrun_cnt), 64'(3));
    chk("boundary_accept_writedata_zero", 64'(writedata), 64'(0));
    wait_tick(t);
    chk("boundary_pair_plays_next", 64'(writedata), 64'hB0DA0001);
    repeat (100) @(negedge Clk);
    offer(32'h11110001, 32'h22220001);
    sample_valid = 1'b0;
    wait_tick(t);
    chk("midframe_pair_plays", 64'(writedata), 64'h11110001);
    chk("midframe_underrun_unchanged", 64'(underrun_cnt), 64'(3));

    // backpressure with valid held throughout
    acc_prev = 0;
    for (int k = 0; k < 5; k++) begin
      offer(32'hA0000000 + 32'(k), 32'hC0000000 + 32'(k));
      chk("bp_ready_low_when_pending", 64'(sample_ready), 64'(0));
      if (k > 0) chk("bp_one_accept_per_frame", 64'(cyc - acc_prev), 64'(256));
      acc_prev = cyc;
    end
    sample_valid = 1'b0;
    wait_tick(t);
    chk("bp_last_pair_plays", 64'(writedata), 64'hA0000004);

    // stop mid-left-slot, with a pair pending and a re-enable during STOP
    offer(32'hDEAD0001, 32'hDEAD0002);
    sample_valid = 1'b0;
    repeat (30) @(negedge Clk);
    enable      = 1'b0;
    urun_before = underrun_cnt;
    repeat (10) @(negedge Clk);
    chk("stop_clocks_continue", 64'(write), 64'(1));
    enable   = 1'b1;
    n        = 0;
    saw_tick = 0;
    while (write && n < 400) begin
      @(negedge Clk);
      n++;
      if (frame_tick) saw_tick = 1;
    end
    chk("stop_reaches_idle", 64'(write), 64'(0));
    chk("stop_at_frame_boundary", 64'(cyc - t), 64'(256));
    chk("stop_no_frame_tick", 64'(saw_tick), 64'(0));
    chk("stop_sclk", 64'(SCLK), 64'(0));
    chk("stop_lrclk", 64'(LRCLK), 64'(0));
    chk("stop_writedata", 64'(writedata), 64'(0));
    chk("stop_sample_ready", 64'(sample_ready), 64'(0));
    chk("stop_underrun_unchanged", 64'(underrun_cnt), 64'(urun_before));
    offer(32'h55550001, 32'h55550002);
    sample_valid = 1'b0;
    wait_tick(t);
    chk("restart_plays_new_pair", 64'(writedata), 64'h55550001);

    // reset in the right slot at bit 17
    repeat (198) @(negedge Clk);
    chk("reset_point_right_slot", 64'(LRCLK), 64'(1));
    Reset  = 1'b1;
    enable = 1'b0;
    @(negedge Clk);
    chk("midreset_sclk", 64'(SCLK), 64'(0));
    chk("midreset_lrclk", 64'(LRCLK), 64'(0));
    chk("midreset_write", 64'(write), 64'(0));
    chk("midreset_writedata", 64'(writedata), 64'(0));
    chk("midreset_frame_tick", 64'(frame_tick), 64'(0));
    chk("midreset_sample_ready", 64'(sample_ready), 64'(0));
    chk("midreset_underrun_cnt", 64'(underrun_cnt), 64'(0));
    Reset = 1'b0;

    // saturation
    enable = 1'b1;
    offer(32'h77770001, 32'h77770002);
    sample_valid = 1'b0;
    wait_tick(t);
    chk("sat_first_pair", 64'(writedata), 64'h77770001);
    force dut.urun_q = 16'hFFFE;
    m_urun = 16'hFFFE;
    @(negedge Clk);
    release dut.urun_q;
    for (int k = 0; k < 3; k++) begin
      wait_tick(t);
      chk("sat_underrun_cnt", 64'(underrun_cnt), 64'hFFFF);
    end

    enable = 1'b0;
    repeat (2) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
